// File: rtl/ahb_slave_mem.sv
// AHB-Lite word-addressed memory responder with WAIT_STATES wait cycles per OKAY data phase.
// Define AHB_SLAVE_ERROR_RESP_EN to enable the two-cycle ERROR response for illegal transfers.
module ahb_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic                  HREADY,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int BO     = $clog2(NBYTES);
  localparam int IW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0] SIZE_MAX = 3'(BO);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * NBYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR1 = 2'd2;
  localparam logic [1:0] S_ERR2 = 2'd3;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              dp_vld;
  logic              dp_write;
  logic              dp_inr;
  logic [IW-1:0]     dp_idx;
  logic [BO-1:0]     dp_off;
  logic [2:0]        dp_size;

  logic              accept;
  logic              in_range;
  logic              addr_err;
  logic              final_dp;
  logic [2:0]        size_eff;
  logic [2:0]        amask_eff;
  logic [7:0]        lane8;
  logic [NBYTES-1:0] wstrb;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic              unused_ok;

  function automatic logic [2:0] low_mask(input logic [2:0] s);
    case (s)
      3'd0:    return 3'b000;
      3'd1:    return 3'b001;
      3'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

  assign accept    = HSEL & HREADY & HTRANS[1] & ((state == S_IDLE) | (state == S_ERR2));
  assign in_range  = HADDR < MEM_BYTES;
  assign size_eff  = (HSIZE > SIZE_MAX) ? SIZE_MAX : HSIZE;
  assign amask_eff = low_mask(size_eff);

`ifdef AHB_SLAVE_ERROR_RESP_EN
  assign addr_err = ~in_range | (HSIZE > SIZE_MAX) | ((HADDR[2:0] & low_mask(HSIZE)) != 3'b000);
  assign HRESP    = (state == S_ERR1) | (state == S_ERR2);
`else
  assign addr_err = 1'b0;
  assign HRESP    = 1'b0;
`endif

  assign HREADYOUT = ~((state == S_WAIT) | (state == S_ERR1));
  // The ready cycle after an accepted OKAY transfer is always spent in IDLE.
  assign final_dp  = dp_vld & (state == S_IDLE);
  assign HRDATA    = (final_dp & ~dp_write & dp_inr) ? mem[dp_idx] : '0;

  always_comb begin
    case (dp_size)
      3'd0:    lane8 = 8'h01;
      3'd1:    lane8 = 8'h03;
      3'd2:    lane8 = 8'h0F;
      default: lane8 = 8'hFF;
    endcase
  end

  assign wstrb = lane8[NBYTES-1:0] << dp_off;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      dp_vld   <= 1'b0;
      dp_write <= 1'b0;
      dp_inr   <= 1'b0;
      dp_idx   <= '0;
      dp_off   <= '0;
      dp_size  <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= S_IDLE;
        end
        S_ERR1: state <= S_ERR2;
        default: begin
          dp_vld <= 1'b0;
          state  <= S_IDLE;
          if (accept) begin
            dp_write <= HWRITE;
            dp_inr   <= in_range;
            dp_idx   <= HADDR[BO +: IW];
            dp_off   <= HADDR[BO-1:0] & ~amask_eff[BO-1:0];
            dp_size  <= size_eff;
            if (addr_err) begin
              state <= S_ERR1;
            end else begin
              dp_vld <= 1'b1;
              if (WAIT_STATES != 0) begin
                state <= S_WAIT;
                cnt   <= 4'(WAIT_STATES);
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge hclk) begin
    if (final_dp && dp_write && dp_inr) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wstrb[b]) mem[dp_idx][b*8 +: 8] <= HWDATA[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Drives two responders (WAIT_STATES=0 and 1) from one pipelined master and checks them
// against a byte-array memory model computed from the transfer rules.
module tb_ahb_slave_mem;
  logic hclk = 1'b0;
  always #5 hclk = ~hclk;

  logic        hresetn;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  hsel;
  wire         rdy0, rdy1, resp0, resp1;
  wire  [31:0] rdata0, rdata1;

  ahb_slave_mem #(.WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hresetn(hresetn), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd1), .HPROT(4'd3), .HREADY(rdy0),
    .HWDATA(hwdata), .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0));

  ahb_slave_mem #(.WAIT_STATES(1)) u_ws1 (
    .hclk(hclk), .hresetn(hresetn), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd1), .HPROT(4'd3), .HREADY(rdy1),
    .HWDATA(hwdata), .HREADYOUT(rdy1), .HRESP(resp1), .HRDATA(rdata1));

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] t_addr  [128];
  logic        t_wr    [128];
  logic [2:0]  t_size  [128];
  logic [31:0] t_wdata [128];
  logic [31:0] obs_rdata [128];
  int          tn;
  int          ncyc;
  logic [7:0]  refm [2][4096];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic get_rdy(input int d);
    return (d != 0) ? rdy1 : rdy0;
  endfunction

  function automatic logic get_resp(input int d);
    return (d != 0) ? resp1 : resp0;
  endfunction

  function automatic logic [31:0] get_rdata(input int d);
    return (d != 0) ? rdata1 : rdata0;
  endfunction

  function automatic logic exp_err(input logic [31:0] a, input logic [2:0] s);
`ifdef AHB_SLAVE_ERROR_RESP_EN
    return (a >= 32'd4096) || (s > 3'd2) || ((a & ((32'd1 << s) - 32'd1)) != 32'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic add(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] dat);
    t_addr[tn] = a; t_wr[tn] = w; t_size[tn] = s; t_wdata[tn] = dat;
    tn++;
  endtask

  // Apply an OKAY transfer to the model; returns the word a read should see.
  task automatic model_apply(input int d, input int i, output logic [31:0] exp_rd);
    int se, nb, base, off;
    se = (t_size[i] > 3'd2) ? 2 : int'(t_size[i]);
    nb = 1 << se;
    base = int'(t_addr[i]) - int'(t_addr[i]) % 4;
    off = (int'(t_addr[i]) % 4) / nb * nb;
    exp_rd = 32'd0;
    if (t_addr[i] < 32'd4096) begin
      if (t_wr[i]) begin
        for (int k = 0; k < nb; k++) refm[d][base + off + k] = t_wdata[i][(off + k)*8 +: 8];
      end else begin
        for (int k = 0; k < 4; k++) exp_rd[k*8 +: 8] = refm[d][base + k];
      end
    end
  endtask

  task automatic run(input int d);
    int ai = 0, dpi = -1, done = 0, waits = 0;
    logic rp = 1'b1, pres = 1'b0, r, er;
    logic [31:0] exp_rd;
    hsel = 2'b00;
    hsel[d] = 1'b1;
    ncyc = 0;
    for (int cyc = 0; cyc < 40*tn + 40 && done < tn; cyc++) begin
      @(negedge hclk);
      ncyc++;
      if (rp) begin
        dpi = pres ? ai : -1;
        if (pres) ai++;
        waits = 0;
      end
      r = get_rdy(d);
      if (dpi >= 0) begin
        er = exp_err(t_addr[dpi], t_size[dpi]);
        chk("hresp", 32'(get_resp(d)), 32'(er));
        if (!r) begin
          waits++;
          chk("hrdata_wait", get_rdata(d), 32'd0);
        end else begin
          chk("wait_cycles", 32'(waits), er ? 32'd1 : 32'(d));
          obs_rdata[dpi] = get_rdata(d);
          if (!er) begin
            model_apply(d, dpi, exp_rd);
            if (!t_wr[dpi]) chk("hrdata", get_rdata(d), exp_rd);
          end
          done++;
        end
      end
      pres = (ai < tn);
      if (pres) begin
        haddr = t_addr[ai]; hwrite = t_wr[ai]; hsize = t_size[ai];
        htrans = (ai == 0) ? 2'b10 : 2'b11;
      end else begin
        htrans = 2'b00;
      end
      hwdata = (dpi >= 0) ? t_wdata[dpi] : 32'd0;
      rp = r;
    end
    chk("complete", 32'(done), 32'(tn));
    htrans = 2'b00;
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4096; k++) refm[d][k] = 8'h00;
    hresetn = 1'b0; haddr = '0; hwdata = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2; hsel = 2'b00;
    repeat (2) @(negedge hclk);
    chk("rst_rdy0", 32'(rdy0), 32'd1);
    chk("rst_rdy1", 32'(rdy1), 32'd1);
    chk("rst_resp", 32'({resp1, resp0}), 32'd0);
    chk("rst_rdata", rdata0 | rdata1, 32'd0);
    hresetn = 1'b1;

    for (int d = 0; d < 2; d++) begin
      tn = 0;
      for (int k = 0; k < 64; k++) add(32'(4*k), 1'b1, 3'd2, $urandom);
      run(d);
    end

    tn = 0;
    add(32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
    add(32'h10, 1'b0, 3'd2, 32'h0);
    run(1);
    chk("rd_deadbeef", obs_rdata[1], 32'hDEADBEEF);
    chk("ws1_cycles", 32'(ncyc), 32'd5);

    tn = 0;
    add(32'h10, 1'b1, 3'd2, 32'h11223344);
    add(32'h13, 1'b1, 3'd0, 32'hAA000000);
    add(32'h10, 1'b0, 3'd2, 32'h0);
    run(1);
    chk("byte_lane", obs_rdata[2], 32'hAA223344);

    tn = 0;
    for (int k = 0; k < 4; k++) add(32'h20 + 32'(4*k), 1'b1, 3'd2, 32'hA0B0C000 + 32'(k));
    for (int k = 0; k < 4; k++) add(32'h20 + 32'(4*k), 1'b0, 3'd2, 32'h0);
    run(0);
    chk("b2b_cycles", 32'(ncyc), 32'd9);
    for (int k = 0; k < 4; k++) chk("b2b_rd", obs_rdata[4 + k], 32'hA0B0C000 + 32'(k));

    for (int d = 0; d < 2; d++) begin
      tn = 0;
      add(32'h1000, 1'b1, 3'd2, 32'h12345678);
      add(32'h1000, 1'b0, 3'd2, 32'h0);
      add(32'h01, 1'b1, 3'd1, 32'h5A5AC3C3);
      add(32'h00, 1'b0, 3'd2, 32'h0);
      add(32'h00, 1'b0, 3'd2, 32'h0);
      run(d);
      chk("oor_rd", obs_rdata[1], 32'd0);
    end

    for (int d = 0; d < 2; d++) begin
      tn = 0;
      for (int k = 0; k < 60; k++) begin
        logic [31:0] a;
        logic [2:0] s;
        s = 3'($urandom_range(0, 3));
        a = ($urandom_range(0, 9) == 0) ? 32'h1000 + 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 32'd1);
        add(a, 1'($urandom_range(0, 1)), s, $urandom);
      end
      run(d);
    end

    @(negedge hclk);
    hsel = 2'b10; haddr = 32'h40; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    @(negedge hclk);
    htrans = 2'b00; hwdata = 32'hCAFEF00D;
    chk("rst_in_wait", 32'(rdy1), 32'd0);
    #1 hresetn = 1'b0;
    #1;
    chk("async_rdy", 32'(rdy1), 32'd1);
    chk("async_resp", 32'(resp1), 32'd0);
    chk("async_rdata", rdata1, 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    tn = 0;
    add(32'h40, 1'b0, 3'd2, 32'h0);
    run(1);
    chk("dropped_write", obs_rdata[0], {refm[1][67], refm[1][66], refm[1][65], refm[1][64]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
